regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file: one write port, two independent read ports, plus a hardware initialisation sweep. It replaces the fixed 8×8 single-read register file in the lab datapath and feeds both ALU operands in one cycle. An asynchronous clear zeroes the array. A request-driven sweep loads a programmable value into every entry, one entry per clock.

## Interface
Parameters:
- WIDTH, 8, data width of each entry in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- INIT_VAL, 0, value written to every entry by the init sweep; WIDTH bits.
- R0_ZERO, 0, when 1, entry 0 always reads as zero and writes to it are discarded.

Derived constant: AW = $clog2(DEPTH).

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous and active-high; zeroes all entries and returns the FSM to IDLE.
- en  in  1  write enable, sampled at posedge clk.
- wsel  in  AW  write address.
- d  in  WIDTH  write data.
- rsel_a  in  AW  read address, port A.
- rsel_b  in  AW  read address, port B.
- qa  out  WIDTH  read data, port A; combinational.
- qb  out  WIDTH  read data, port B; combinational.
- init_req  in  1  request to start the init sweep; a one-cycle pulse is enough.
- busy  out  1  high while a sweep is in progress.

## Operation
- Storage: DEPTH × WIDTH registers.
- Reads: qa = entry[rsel_a], qb = entry[rsel_b]. No clock involved. Both ports may address the same entry.
- Write: at posedge clk, when en=1 and state is IDLE, entry[wsel] <= d.
- R0_ZERO=1:
  - A write to address 0 is dropped.
  - A read of address 0 returns 0, including during a sweep and with bypass compiled in.
- FSM states: IDLE and SWEEP, plus a pointer ptr (AW bits).
- IDLE → SWEEP: when init_req=1 at posedge clk; ptr <= 0.
- In SWEEP, on each posedge:
  - entry[ptr] <= INIT_VAL, then ptr <= ptr+1.
  - If ptr = DEPTH-1, write the last entry and go to IDLE; ptr <= 0.
- SWEEP → IDLE happens without wrap-around: ptr never passes DEPTH-1.
- busy = (state == SWEEP).
- During SWEEP:
  - en writes are ignored, not queued.
  - init_req is ignored.
  - Reads stay live and show a mix of swept and unswept entries.
- init_req and en both high in IDLE: the external write is dropped and the sweep starts. The sweep has priority.
- clr mid-sweep: all entries become 0 immediately, state goes to IDLE, ptr 0, busy 0. The sweep is not resumed.

## Timing
- Reset values: every entry 0, qa=qb=0, busy=0, state IDLE, ptr 0.
- Write latency: data written at edge N is visible on qa/qb right after edge N (without bypass).
- Sweep:
  - init_req sampled at edge N gives busy=1 from N until after edge N+DEPTH.
  - The last entry is written at edge N+DEPTH.
  - busy is 0 after that edge, so en is honoured at edge N+DEPTH+1.
- Total sweep: DEPTH cycles. Throughput: one write per cycle in IDLE.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When en=1, busy=0 and rsel_x == wsel (and not the R0_ZERO address 0 case), qx = d combinationally in the same cycle.
  - This is write-through forwarding.
  - Applies to each port independently.
- Undefined: qx always shows stored contents. The new value appears only after the edge.

## Structure
- Shared package regfile_pkg holds:
  - the FSM state enum (IDLE, SWEEP);
  - a helper function returning $clog2 with a minimum of 1.
- One natural sub-module: regfile_init_fsm. It owns state and ptr, and drives busy, the sweep write enable, the sweep address and the write-blocking signal into the array.
- The array and read muxes stay in the top module.

## Test plan
- Reset: assert clr mid-run → qa=qb=0 for every address; busy=0.
- Dual read: write 8'hA5 to addr 3 and 8'h5A to addr 6; set rsel_a=3, rsel_b=6 → qa=A5, qb=5A. With rsel_a=rsel_b=3 → both A5.
- Sweep (DEPTH=8, INIT_VAL=8'h3C):
  - Pulse init_req → busy high exactly 8 cycles; afterwards all entries read 3C.
  - en=1 to addr 2 with 8'hFF during the sweep → addr 2 reads 3C.
- clr mid-sweep: assert clr at sweep cycle 4 → all entries 0, busy 0. A following write to addr 7 with 8'h11 lands.
- R0_ZERO=1: write 8'h77 to addr 0 → qa at addr 0 reads 0. Write to addr 1 reads back normally.
- Bypass: with REGFILE_BYPASS_EN defined, en=1, wsel=rsel_a=5, d=8'h9E → qa=9E in the same cycle. Without the macro, qa shows the old value until the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and address-width helper for the regfile_2r1w block.
package regfile_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_init_fsm.sv
// regfile_init_fsm: init sweep controller; steps a pointer over every entry, one per clock.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_init_req,
  output logic          o_busy,
  output logic          o_sweep_we,
  output logic [AW-1:0] o_sweep_addr,
  output logic          o_wr_block
);
  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic          w_last;
  assign w_last = (r_ptr == AW'(DEPTH - 1));
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_init_req) begin
        r_state <= SWEEP;
        r_ptr   <= '0;
        r_busy  <= 1'b1;
      end
    end else begin
      r_ptr   <= w_last ? '0 : r_ptr + 1'b1;
      r_state <= w_last ? IDLE : SWEEP;
      r_busy  <= !w_last;
    end
  end
  assign o_busy       = r_busy;
  assign o_sweep_we   = r_busy;
  assign o_sweep_addr = r_ptr;
  // a request in IDLE already wins over a same-cycle external write
  assign o_wr_block   = r_busy | i_init_req;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with async clear and init sweep.
// Define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter bit R0_ZERO = 1'b0,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    rsel_a,
  input  logic [AW-1:0]    rsel_b,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic             init_req,
  output logic             busy
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_sweep_we;
  logic [AW-1:0]    w_sweep_addr;
  logic             w_wr_block;
  logic             w_ext_we;
  logic             w_fwd;
  regfile_init_fsm #(.DEPTH(DEPTH)) u_fsm (
    .clk          (clk),
    .clr          (clr),
    .i_init_req   (init_req),
    .o_busy       (busy),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr),
    .o_wr_block   (w_wr_block)
  );
  assign w_ext_we = en && !w_wr_block && !(R0_ZERO && wsel == '0);
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= INIT_VAL;
    end else if (w_ext_we) begin
      r_mem[wsel] <= d;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign w_fwd = en && !busy;
`else
  assign w_fwd = 1'b0;
`endif
  assign qa = (R0_ZERO && rsel_a == '0) ? '0 : (w_fwd && rsel_a == wsel) ? d : r_mem[rsel_a];
  assign qb = (R0_ZERO && rsel_b == '0) ? '0 : (w_fwd && rsel_b == wsel) ? d : r_mem[rsel_b];
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed and random stimulus against an array-based reference model.
module tb_regfile_2r1w;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [2:0] wsel = '0;
  logic [7:0] d = '0;
  logic [2:0] rsel_a = '0;
  logic [2:0] rsel_b = '0;
  logic [7:0] qa, qb;
  logic       init_req = 1'b0;
  logic       busy;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_mem [8];
  int m_left = 0;
  int m_idx = 0;
  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .INIT_VAL(8'h3C), .R0_ZERO(1'b1)) dut (
    .clk(clk), .clr(clr), .en(en), .wsel(wsel), .d(d),
    .rsel_a(rsel_a), .rsel_b(rsel_b), .qa(qa), .qb(qb),
    .init_req(init_req), .busy(busy)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (en && m_left == 0 && a == wsel) return d;
`endif
    return m_mem[a];
  endfunction
  task automatic model_edge();
    if (m_left > 0) begin
      m_mem[m_idx] = 8'h3C;
      m_idx++;
      m_left--;
    end else if (init_req) begin
      m_left = 8;
      m_idx = 0;
    end else if (en && wsel != 3'd0) begin
      m_mem[wsel] = d;
    end
  endtask
  task automatic step();
    @(negedge clk);
    chk("qa", qa, exp_rd(rsel_a));
    chk("qb", qb, exp_rd(rsel_b));
    chk("busy", busy, m_left > 0);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic do_clr();
    en = 1'b0;
    init_req = 1'b0;
    clr = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_left = 0;
    m_idx = 0;
    for (int a = 0; a < 8; a++) begin
      rsel_a = 3'(a);
      rsel_b = 3'(7 - a);
      #1;
      chk("clr_qa", qa, 8'h00);
      chk("clr_qb", qb, 8'h00);
    end
    chk("clr_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    en = 1'b1;
    wsel = a;
    d = v;
    step();
    en = 1'b0;
  endtask
  task automatic sweep_all(input int stop_at);
    int n;
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (n == stop_at) begin
        do_clr();
        return;
      end
      en = (n == 2);
      wsel = 3'd2;
      d = 8'hFF;
      init_req = (n == 3);
      rsel_a = 3'(n);
      rsel_b = 3'd2;
      step();
      n++;
    end
    en = 1'b0;
    init_req = 1'b0;
    chk("busy_len", n, 8);
  endtask
  initial begin
    #2;
    do_clr();
    wr(3'd3, 8'hA5);
    wr(3'd6, 8'h5A);
    rsel_a = 3'd3;
    rsel_b = 3'd6;
    step();
    chk("dual_a", qa, 8'hA5);
    chk("dual_b", qb, 8'h5A);
    rsel_b = 3'd3;
    step();
    chk("same_b", qb, 8'hA5);
    sweep_all(99);
    for (int a = 0; a < 8; a++) begin
      rsel_a = 3'(a);
      step();
    end
    rsel_a = 3'd2;
    #1;
    chk("sweep_a2", qa, 8'h3C);
    sweep_all(4);
    wr(3'd7, 8'h11);
    rsel_a = 3'd7;
    step();
    chk("wr7", qa, 8'h11);
    wr(3'd0, 8'h77);
    rsel_a = 3'd0;
    step();
    chk("r0", qa, 8'h00);
    wr(3'd1, 8'h81);
    rsel_a = 3'd1;
    step();
    chk("r1", qa, 8'h81);
    wr(3'd5, 8'h42);
    en = 1'b1;
    wsel = 3'd5;
    rsel_a = 3'd5;
    d = 8'h9E;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass", qa, 8'h9E);
`else
    chk("no_bypass", qa, 8'h42);
`endif
    step();
    en = 1'b0;
    step();
    chk("after_edge", qa, 8'h9E);
    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom_range(1));
      wsel = 3'($urandom_range(7));
      d = 8'($urandom);
      rsel_a = 3'($urandom_range(7));
      rsel_b = ($urandom_range(3) == 0) ? wsel : 3'($urandom_range(7));
      init_req = ($urandom_range(24) == 0);
      if ($urandom_range(60) == 0) do_clr();
      else step();
    end
    init_req = 1'b0;
    en = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
